// File: rtl/param_updown_counter.sv
// Generic up/down counter: wraps or saturates at a programmable terminal value, with load and clear.
// Latency: count/tc/ovf update on the sampling edge; result is combinational from the registered count.
// Backpressure: none; the counter acts on every enabled edge, with clr > load > en priority.
module param_updown_counter #(
   parameter int unsigned WIDTH   = 6,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic             mode_sat,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] cmp_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             result,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO    = '0;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             term;

   // Terminal condition on the current count: at/above limit going up, at zero going down.
   // Counts loaded above limit are treated as terminal so an up-count never runs past limit.
   always_comb begin
      term = 1'b0;
      if (dir) begin
         term = (count_q >= limit);
      end else begin
         term = (count_q == ZERO);
      end
   end

   // Next-state: clr beats load beats en; tc only pulses on an enabled terminal edge.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = ZERO;
      end else if (load) begin
         count_d = load_val;
      end else if (en) begin
         if (!term) begin
            count_d = dir ? (count_q + ONE) : (count_q - ONE);
         end else begin
            tc_d = 1'b1;
            if (!mode_sat) begin
               count_d = dir ? ZERO : limit;
            end
         end
      end
      // A new terminal event wins over a coincident clear request.
      if (tc_d) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // State registers; reset forces the count and flags immediately, without a clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= RST_CNT;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count  = count_q;
   assign tc     = tc_q;
   assign ovf    = ovf_q;
   assign result = (count_q == cmp_val);

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

   logic       clock;
   logic       reset;
   logic       en, clr, load, dir, mode_sat, ovf_clr;
   logic [5:0] load_val, limit, cmp_val;
   logic [5:0] count;
   logic       tc, result, ovf;

   int nchecks = 0;
   int nfail   = 0;

   param_updown_counter #(.WIDTH(6), .RST_VAL(0)) dut (
      .clock(clock), .reset(reset), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .dir(dir), .mode_sat(mode_sat), .limit(limit),
      .cmp_val(cmp_val), .ovf_clr(ovf_clr), .count(count), .tc(tc),
      .result(result), .ovf(ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      en = 0; clr = 0; load = 0; dir = 1; mode_sat = 0; ovf_clr = 0;
      load_val = 6'd0; limit = 6'd63; cmp_val = 6'd0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      #2;
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL reset_count got %0d want 0", count); end
      nchecks++; if (tc !== 1'b0) begin nfail++; $display("FAIL reset_tc got %b want 0", tc); end
      nchecks++; if (ovf !== 1'b0) begin nfail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      nchecks++; if (result !== 1'b1) begin nfail++; $display("FAIL reset_result got %b want 1", result); end
      #6; // t=8, after the t=5 edge which reset must block
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL reset_hold_count got %0d want 0", count); end
   endtask

   task automatic test_wrap_up();
      logic [5:0] e;
      limit = 6'd63; dir = 1; mode_sat = 0; en = 1; cmp_val = 6'd50;
      reset = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         step();
         e = 6'(k % 64);
         nchecks++; if (count !== e) begin nfail++; $display("FAIL wrap_count edge %0d got %0d want %0d", k, count, e); end
         nchecks++; if (tc !== (k == 64)) begin nfail++; $display("FAIL wrap_tc edge %0d got %b want %b", k, tc, (k == 64)); end
         nchecks++; if (ovf !== (k >= 64)) begin nfail++; $display("FAIL wrap_ovf edge %0d got %b want %b", k, ovf, (k >= 64)); end
      end
   endtask

   task automatic test_load_down();
      logic [5:0] ec [5];
      logic       et [5];
      ec = '{6'd1, 6'd0, 6'd9, 6'd8, 6'd7};
      et = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      en = 0; limit = 6'd9; dir = 0; mode_sat = 0; load_val = 6'd2; load = 1;
      step();
      load = 0;
      nchecks++; if (count !== 6'd2) begin nfail++; $display("FAIL load_count got %0d want 2", count); end
      nchecks++; if (tc !== 1'b0) begin nfail++; $display("FAIL load_tc got %b want 0", tc); end
      en = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         nchecks++; if (count !== ec[k]) begin nfail++; $display("FAIL down_count step %0d got %0d want %0d", k, count, ec[k]); end
         nchecks++; if (tc !== et[k]) begin nfail++; $display("FAIL down_tc step %0d got %b want %b", k, tc, et[k]); end
      end
   endtask

   task automatic test_saturate();
      logic [5:0] e;
      clr = 1; en = 0;
      step();
      clr = 0;
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL sat_clr_count got %0d want 0", count); end
      limit = 6'd5; dir = 1; mode_sat = 1; en = 1;
      for (int k = 1; k <= 10; k++) begin
         step();
         e = (k < 5) ? 6'(k) : 6'd5;
         nchecks++; if (count !== e) begin nfail++; $display("FAIL sat_count edge %0d got %0d want %0d", k, count, e); end
         nchecks++; if (tc !== (k >= 6)) begin nfail++; $display("FAIL sat_tc edge %0d got %b want %b", k, tc, (k >= 6)); end
      end
      en = 0;
      step();
      nchecks++; if (tc !== 1'b0) begin nfail++; $display("FAIL sat_off_tc got %b want 0", tc); end
      nchecks++; if (count !== 6'd5) begin nfail++; $display("FAIL sat_off_count got %0d want 5", count); end
      // Saturating down at zero holds and keeps tc high.
      clr = 1;
      step();
      clr = 0; dir = 0; en = 1;
      step();
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL sat_down_count got %0d want 0", count); end
      nchecks++; if (tc !== 1'b1) begin nfail++; $display("FAIL sat_down_tc got %b want 1", tc); end
      en = 0;
   endtask

   task automatic test_priority();
      limit = 6'd63; dir = 1; mode_sat = 0;
      clr = 1; load = 1; en = 1; load_val = 6'd7;
      step();
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL prio_clr got %0d want 0", count); end
      clr = 0;
      step();
      nchecks++; if (count !== 6'd7) begin nfail++; $display("FAIL prio_load got %0d want 7", count); end
      nchecks++; if (tc !== 1'b0) begin nfail++; $display("FAIL prio_load_tc got %b want 0", tc); end
      // Load above limit is accepted; the next up edge is terminal and wraps to 0.
      limit = 6'd5; load_val = 6'd20;
      step();
      load = 0;
      nchecks++; if (count !== 6'd20) begin nfail++; $display("FAIL load_above_limit got %0d want 20", count); end
      step();
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL above_limit_wrap got %0d want 0", count); end
      nchecks++; if (tc !== 1'b1) begin nfail++; $display("FAIL above_limit_tc got %b want 1", tc); end
      en = 0;
   endtask

   task automatic test_ovf();
      limit = 6'd63; dir = 1; mode_sat = 0;
      clr = 1;
      step();
      clr = 0;
      nchecks++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_kept_by_clr got %b want 1", ovf); end
      en = 1; ovf_clr = 1;
      step();
      nchecks++; if (ovf !== 1'b0) begin nfail++; $display("FAIL ovf_clear got %b want 0", ovf); end
      nchecks++; if (count !== 6'd1) begin nfail++; $display("FAIL ovf_clear_count got %0d want 1", count); end
      en = 0; ovf_clr = 0; load = 1; load_val = 6'd63;
      step();
      load = 0; en = 1; ovf_clr = 1;
      step();
      nchecks++; if (tc !== 1'b1) begin nfail++; $display("FAIL ovf_set_tc got %b want 1", tc); end
      nchecks++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_set_wins got %b want 1", ovf); end
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL ovf_set_count got %0d want 0", count); end
      en = 0; ovf_clr = 0;
   endtask

   task automatic test_limit_zero();
      limit = 6'd0; dir = 1; mode_sat = 0; en = 1;
      for (int k = 0; k < 2; k++) begin
         step();
         nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL lim0_up_count got %0d want 0", count); end
         nchecks++; if (tc !== 1'b1) begin nfail++; $display("FAIL lim0_up_tc got %b want 1", tc); end
      end
      dir = 0;
      step();
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL lim0_down_count got %0d want 0", count); end
      nchecks++; if (tc !== 1'b1) begin nfail++; $display("FAIL lim0_down_tc got %b want 1", tc); end
      en = 0;
   endtask

   task automatic test_compare();
      logic [5:0] ec [5];
      logic       er [5];
      ec = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
      er = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      limit = 6'd63; dir = 1; mode_sat = 0; cmp_val = 6'd12;
      load = 1; load_val = 6'd9;
      step();
      load = 0; en = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         nchecks++; if (count !== ec[k]) begin nfail++; $display("FAIL cmp_count step %0d got %0d want %0d", k, count, ec[k]); end
         nchecks++; if (result !== er[k]) begin nfail++; $display("FAIL cmp_result step %0d got %b want %b", k, result, er[k]); end
      end
      en = 0;
   endtask

   task automatic test_async_reset();
      limit = 6'd30; dir = 1; mode_sat = 1; cmp_val = 6'd0;
      load = 1; load_val = 6'd29;
      step();
      load = 0; en = 1;
      step();
      step();
      nchecks++; if (count !== 6'd30) begin nfail++; $display("FAIL pre_reset_count got %0d want 30", count); end
      nchecks++; if (tc !== 1'b1) begin nfail++; $display("FAIL pre_reset_tc got %b want 1", tc); end
      #3;
      reset = 1'b0;
      #1;
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL async_count got %0d want 0", count); end
      nchecks++; if (tc !== 1'b0) begin nfail++; $display("FAIL async_tc got %b want 0", tc); end
      nchecks++; if (ovf !== 1'b0) begin nfail++; $display("FAIL async_ovf got %b want 0", ovf); end
      nchecks++; if (result !== 1'b1) begin nfail++; $display("FAIL async_result got %b want 1", result); end
      step();
      nchecks++; if (count !== 6'd0) begin nfail++; $display("FAIL reset_held_count got %0d want 0", count); end
      limit = 6'd63; mode_sat = 0;
      reset = 1'b1;
      step();
      nchecks++; if (count !== 6'd1) begin nfail++; $display("FAIL resume_count got %0d want 1", count); end
      en = 0;
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_load_down();
      test_saturate();
      test_priority();
      test_ovf();
      test_limit_zero();
      test_compare();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule
